// File: rtl/bcd_scan_if.sv
// rtl/bcd_scan_if.sv - BCD input and seven-segment output bundle for bcd_scan_display
interface bcd_scan_if;
  logic [23:0] bcd_in;
  logic [5:0]  dp_mask;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [5:0]  an;
  logic        frame_done;

  modport master (
    output bcd_in, dp_mask, blank_lz,
    input  seg, an, frame_done
  );

  modport slave (
    input  bcd_in, dp_mask, blank_lz,
    output seg, an, frame_done
  );
endinterface

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - six-digit multiplexed seven-segment driver for packed BCD hh:mm:ss
module bcd_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic      clk,
  input  logic      rst,
  bcd_scan_if.slave disp
);
  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       dig;
  logic [23:0]      shadow;
  logic [7:0]       seg_q;
  logic [5:0]       an_q;
  logic             frame_done_q;

  logic       tick;
  logic       wrap;
  logic [3:0] nib;
  logic [6:0] seg7;
  logic [7:0] seg_next;
  logic [5:0] an_next;

  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign wrap = tick && (dig == 3'd5);
  assign nib  = shadow[{dig, 2'b00} +: 4];

  always_comb begin
    seg7 = 7'h3F;
    case (nib)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase
  end

  // Blanking a leading zero also suppresses its decimal point.
  always_comb begin
    seg_next = {~disp.dp_mask[dig], seg7};
    if ((dig == 3'd5) && disp.blank_lz && (nib == 4'd0)) begin
      seg_next = 8'hFF;
    end
    an_next = 6'h3F;
    if (div_cnt >= DIV_W'(GUARD)) begin
      an_next = ~(6'b1 << dig);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      dig          <= 3'd0;
      shadow       <= 24'h0;
      seg_q        <= 8'hFF;
      an_q         <= 6'h3F;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        dig <= (dig == 3'd5) ? 3'd0 : dig + 3'd1;
      end
      if (wrap) begin
        shadow <= disp.bcd_in;
      end
      frame_done_q <= wrap;
      seg_q        <= seg_next;
      an_q         <= an_next;
    end
  end

  assign disp.seg        = seg_q;
  assign disp.an         = an_q;
  assign disp.frame_done = frame_done_q;
endmodule
